alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, sets the number of cycles the shared ALU stage is occupied per operation (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req0 / req1  input  1  request from requester 0 / 1; held high until the matching done pulse.
REQ-005 op0 / op1  input  2  operation select: 00 add, 01 sub, 10 and, 11 or.
REQ-006 a0, b0 / a1, b1  input  3  unsigned operands of requester 0 / 1.
REQ-007 gnt0 / gnt1  output  1  one-cycle pulse: the requester's operands have been latched.
REQ-008 done0 / done1  output  1  one-cycle pulse: result belongs to this requester.
REQ-009 result  output  4  registered ALU result; holds last value until the next done pulse.
REQ-010 busy  output  1  high in every non-IDLE state.

Function
REQ-011 FSM states SHALL be IDLE, EXEC, DONE; all outputs SHALL be registered.
REQ-012 IDLE: if any req is high at a clock edge, the arbiter SHALL latch the winner's op/a/b, enter EXEC, and assert the winner's gnt for the first EXEC cycle only.
REQ-013 Arbitration SHALL be round-robin: a 1-bit pointer marks the preferred requester; on simultaneous requests the preferred one wins; after each DONE the pointer SHALL point to the requester not just served.
REQ-014 Single request SHALL win regardless of pointer.
REQ-015 EXEC SHALL last exactly EXEC_CYCLES cycles (down-counter loaded at grant); on its final cycle the result SHALL be computed from latched operands and the FSM SHALL enter DONE.
REQ-016 DONE SHALL last one cycle: winner's done asserted, result updated, pointer updated, then IDLE.
REQ-017 Latency: req sampled at edge k -> gnt high cycle k+1 -> done high cycle k+1+EXEC_CYCLES; minimum request-to-request service spacing EXEC_CYCLES+2 cycles.
REQ-018 Arithmetic on operands zero-extended to 4 bits, truncated to 4 bits: add = A+B (bit3 = carry); sub = A-B two's complement (bit3 = borrow); and/or bitwise, bit3 = 0.
REQ-019 Requests arriving while busy SHALL be ignored until IDLE; they are served only if still high then.
REQ-020 Operand/op changes after grant SHALL NOT affect the in-flight result.
REQ-021 req dropped after grant SHALL NOT abort the operation; done still pulses.
REQ-022 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously; gnt and done never in the same cycle.

Reset
REQ-023 On rst: state IDLE, gnt0=gnt1=done0=done1=0, busy=0, result=4'b0000, pointer=requester 0, counter cleared.
REQ-024 rst in any state, including mid-EXEC or DONE, SHALL discard the in-flight operation with no done pulse; rst has priority over all other events.
REQ-025 First grant is permitted at the first edge after rst deasserts.

Verification (EXEC_CYCLES=1 unless noted)
REQ-026 rst high 2 cycles, all req low -> all outputs 0, busy 0, result 0000.
REQ-027 req0 only, op0=00, a0=101, b0=110 at edge k -> gnt0 cycle k+1, done0 cycle k+2, result 1011, busy high k+1..k+2.
REQ-028 req0 (add 101+101) and req1 (sub 011-101) raised together after reset -> requester 0 served first, result 1010; then requester 1, result 1110.
REQ-029 req0 and req1 held high continuously, 6 operations -> grants alternate 0,1,0,1,0,1; each done spaced 3 cycles.
REQ-030 rst pulsed during EXEC of a req1 operation (EXEC_CYCLES=3) -> no done1, result stays 0000, next simultaneous request granted to requester 0.
REQ-031 req1 dropped and a1/b1 changed one cycle after gnt1, op1=10, a1=111, b1=010 -> done1 still pulses, result 0010.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two-requester handshake and the shared ALU result bus.
//   master : requester side, drives req/op/a/b and observes gnt/done/result/busy
//   slave  : arbiter side, samples requests and drives the registered responses
interface alu_arbiter_if;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned OPD_W = 3;
  localparam int unsigned RES_W = 4;

  logic             req0;
  logic             req1;
  logic [OP_W-1:0]  op0;
  logic [OP_W-1:0]  op1;
  logic [OPD_W-1:0] a0;
  logic [OPD_W-1:0] b0;
  logic [OPD_W-1:0] a1;
  logic [OPD_W-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic [RES_W-1:0] result;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, busy, result
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, busy, result
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter in front of a shared 2-op-bit, 3-bit-operand ALU.
// A request seen in IDLE latches the winner's operands, occupies the ALU for
// EXEC_CYCLES cycles, then reports the 4-bit result with a one-cycle done pulse.
// Ports:
//   clk  : clock, rising-edge
//   rst  : synchronous active-high reset
//   bus  : alu_arbiter_if.slave (req/op/a/b in; gnt/done/busy/result out, all registered)
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned OPD_W = 3;
  localparam int unsigned RES_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ptr, ptr_nxt;
  logic             owner, owner_nxt;
  logic [OP_W-1:0]  op_l, op_l_nxt;
  logic [OPD_W-1:0] a_l, a_l_nxt;
  logic [OPD_W-1:0] b_l, b_l_nxt;
  logic             gnt0_q, gnt0_nxt;
  logic             gnt1_q, gnt1_nxt;
  logic             done0_q, done0_nxt;
  logic             done1_q, done1_nxt;
  logic             busy_q, busy_nxt;
  logic [RES_W-1:0] result_q, result_nxt;
  logic             win_c;
  logic [RES_W-1:0] alu_c;

  // Shared ALU on latched operands; zero-extended so bit3 carries carry/borrow.
  always_comb begin
    alu_c = '0;
    case (op_l)
      2'b00:   alu_c = RES_W'(a_l) + RES_W'(b_l);
      2'b01:   alu_c = RES_W'(a_l) - RES_W'(b_l);
      2'b10:   alu_c = RES_W'(a_l & b_l);
      default: alu_c = RES_W'(a_l | b_l);
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    op_l_nxt   = op_l;
    a_l_nxt    = a_l;
    b_l_nxt    = b_l;
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    result_nxt = result_q;
    win_c      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Pointer only breaks ties; a lone request always wins.
          win_c     = (bus.req0 && bus.req1) ? ptr : bus.req1;
          owner_nxt = win_c;
          op_l_nxt  = win_c ? bus.op1 : bus.op0;
          a_l_nxt   = win_c ? bus.a1  : bus.a0;
          b_l_nxt   = win_c ? bus.b1  : bus.b0;
          cnt_nxt   = CNT_W'(EXEC_CYCLES);
          gnt0_nxt  = ~win_c;
          gnt1_nxt  = win_c;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // <= 1 keeps an out-of-range count from spinning through a wrap.
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt    = '0;
          result_nxt = alu_c;
          done0_nxt  = ~owner;
          done1_nxt  = owner;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        ptr_nxt   = ~owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb busy_nxt = (state_nxt != IDLE);

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      op_l     <= '0;
      a_l      <= '0;
      b_l      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      op_l     <= op_l_nxt;
      a_l      <= a_l_nxt;
      b_l      <= b_l_nxt;
      gnt0_q   <= gnt0_nxt;
      gnt1_q   <= gnt1_nxt;
      done0_q  <= done0_nxt;
      done1_q  <= done1_nxt;
      busy_q   <= busy_nxt;
      result_q <= result_nxt;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives identical stimulus into an EXEC_CYCLES=1 and an
// EXEC_CYCLES=3 arbiter, checks a directed vector table, a reset-mid-EXEC
// sequence and a random run against a schedule-based reference model.
module tb_alu_arbiter;
  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [2:0] a0, b0, a1, b1;

  alu_arbiter_if bus1 ();
  alu_arbiter_if bus3 ();

  alu_arbiter #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_arbiter #(.EXEC_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus1.req0 = req0;  assign bus3.req0 = req0;
  assign bus1.req1 = req1;  assign bus3.req1 = req1;
  assign bus1.op0  = op0;   assign bus3.op0  = op0;
  assign bus1.op1  = op1;   assign bus3.op1  = op1;
  assign bus1.a0   = a0;    assign bus3.a0   = a0;
  assign bus1.b0   = b0;    assign bus3.b0   = b0;
  assign bus1.a1   = a1;    assign bus3.a1   = a1;
  assign bus1.b1   = b1;    assign bus3.b1   = b1;

  // Observed outputs packed as {gnt0,gnt1,done0,done1,busy,result[3:0]}.
  logic [8:0] obs [2];
  assign obs[0] = {bus1.gnt0, bus1.gnt1, bus1.done0, bus1.done1, bus1.busy, bus1.result};
  assign obs[1] = {bus3.gnt0, bus3.gnt1, bus3.done0, bus3.done1, bus3.busy, bus3.result};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ex_cyc [2] = '{1, 3};

  // Reference model: one transaction at a time, tracked by absolute cycle numbers.
  int m_active [2];
  int m_tgrant [2];
  int m_tdone  [2];
  int m_owner  [2];
  int m_ptr    [2];
  int m_res    [2];
  int m_op     [2];
  int m_a      [2];
  int m_b      [2];

  function automatic int alu_ref(int op, int a, int b);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  // Advance model for instance i at the edge that starts cycle n.
  function automatic void model_edge(int i, int n);
    if (rst) begin
      m_active[i] = 0;
      m_ptr[i]    = 0;
      m_res[i]    = 0;
    end else if (m_active[i] != 0) begin
      if (n == m_tdone[i]) m_res[i] = alu_ref(m_op[i], m_a[i], m_b[i]);
      if (n == m_tdone[i] + 1) begin
        m_active[i] = 0;
        m_ptr[i]    = 1 - m_owner[i];
      end
    end else if (req0 || req1) begin
      m_owner[i]  = (req0 && req1) ? m_ptr[i] : (req1 ? 1 : 0);
      m_op[i]     = (m_owner[i] == 1) ? int'(op1) : int'(op0);
      m_a[i]      = (m_owner[i] == 1) ? int'(a1)  : int'(a0);
      m_b[i]      = (m_owner[i] == 1) ? int'(b1)  : int'(b0);
      m_tgrant[i] = n;
      m_tdone[i]  = n + ex_cyc[i];
      m_active[i] = 1;
    end
  endfunction

  function automatic logic [8:0] model_out(int i, int c);
    logic g, d;
    g = (m_active[i] != 0) && (c == m_tgrant[i]);
    d = (m_active[i] != 0) && (c == m_tdone[i]);
    return {g && (m_owner[i] == 0), g && (m_owner[i] == 1),
            d && (m_owner[i] == 0), d && (m_owner[i] == 1),
            (m_active[i] != 0), 4'(m_res[i])};
  endfunction

  function automatic void cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void cmp_vec(string tag, logic [8:0] act, logic [8:0] exp);
    cmp({tag, ".gnt0"},   int'(act[8]),   int'(exp[8]));
    cmp({tag, ".gnt1"},   int'(act[7]),   int'(exp[7]));
    cmp({tag, ".done0"},  int'(act[6]),   int'(exp[6]));
    cmp({tag, ".done1"},  int'(act[5]),   int'(exp[5]));
    cmp({tag, ".busy"},   int'(act[4]),   int'(exp[4]));
    cmp({tag, ".result"}, int'(act[3:0]), int'(exp[3:0]));
  endfunction

  // One clock: DUT and model see the same inputs, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0, cyc);
    model_edge(1, cyc);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      cmp_vec($sformatf("model.E%0d", ex_cyc[i]), obs[i], model_out(i, cyc));
  endtask

  task automatic set_in(int r, int q0, int q1, int o0, int x0, int y0, int o1, int x1, int y1);
    rst  = 1'(r);
    req0 = 1'(q0);
    req1 = 1'(q1);
    op0  = 2'(o0);
    a0   = 3'(x0);
    b0   = 3'(y0);
    op1  = 2'(o1);
    a1   = 3'(x1);
    b1   = 3'(y1);
  endtask

  typedef struct {
    int         rst, req0, req1, op0, a0, b0, op1, a1, b1;
    logic [8:0] exp;
  } vec_t;

  localparam int N_VEC = 37;
  vec_t vt [N_VEC];

  function automatic vec_t mk(int r, int q0, int q1, int o0, int x0, int y0,
                              int o1, int x1, int y1,
                              int g0, int g1, int d0, int d1, int bz, int res);
    vec_t v;
    v.rst = r;  v.req0 = q0; v.req1 = q1;
    v.op0 = o0; v.a0 = x0;   v.b0 = y0;
    v.op1 = o1; v.a1 = x1;   v.b1 = y1;
    v.exp = {1'(g0), 1'(g1), 1'(d0), 1'(d1), 1'(bz), 4'(res)};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected outputs of the EXEC_CYCLES=1 instance in the cycle after each edge.
    vt[0]  = mk(1, 0,0, 0,0,0, 0,0,0,  0,0,0,0,0, 0);
    vt[1]  = mk(1, 0,0, 0,0,0, 0,0,0,  0,0,0,0,0, 0);
    vt[2]  = mk(0, 1,0, 0,5,6, 0,0,0,  1,0,0,0,1, 0);
    vt[3]  = mk(0, 1,0, 0,5,6, 0,0,0,  0,0,1,0,1, 11);
    vt[4]  = mk(0, 0,0, 0,5,6, 0,0,0,  0,0,0,0,0, 11);
    vt[5]  = mk(0, 0,0, 0,5,6, 0,0,0,  0,0,0,0,0, 11);
    vt[6]  = mk(1, 0,0, 0,0,0, 0,0,0,  0,0,0,0,0, 0);
    vt[7]  = mk(0, 1,1, 0,5,5, 1,3,5,  1,0,0,0,1, 0);
    vt[8]  = mk(0, 1,1, 0,5,5, 1,3,5,  0,0,1,0,1, 10);
    vt[9]  = mk(0, 0,1, 0,5,5, 1,3,5,  0,0,0,0,0, 10);
    vt[10] = mk(0, 0,1, 0,5,5, 1,3,5,  0,1,0,0,1, 10);
    vt[11] = mk(0, 0,1, 0,5,5, 1,3,5,  0,0,0,1,1, 14);
    vt[12] = mk(0, 0,0, 0,5,5, 1,3,5,  0,0,0,0,0, 14);
    begin
      int r;
      r = 14;
      for (int j = 0; j < 18; j++) begin
        int k, w;
        k = j % 3;
        w = (j / 3) % 2;
        if (k == 1) r = (w == 0) ? 3 : 5;
        vt[13 + j] = mk(0, 1,1, 0,1,2, 3,4,1,
                        int'(k == 0 && w == 0), int'(k == 0 && w == 1),
                        int'(k == 1 && w == 0), int'(k == 1 && w == 1),
                        int'(k != 2), r);
      end
    end
    vt[31] = mk(0, 0,1, 0,1,2, 2,7,2,  0,1,0,0,1, 5);
    vt[32] = mk(0, 0,0, 0,1,2, 3,0,5,  0,0,0,1,1, 2);
    vt[33] = mk(0, 0,0, 0,1,2, 3,0,5,  0,0,0,0,0, 2);
    vt[34] = mk(0, 1,0, 1,0,1, 0,0,0,  1,0,0,0,1, 2);
    vt[35] = mk(1, 1,0, 1,0,1, 0,0,0,  0,0,0,0,0, 0);
    vt[36] = mk(0, 0,0, 0,0,0, 0,0,0,  0,0,0,0,0, 0);

    set_in(1, 0,0, 0,0,0, 0,0,0);
    for (int i = 0; i < N_VEC; i++) begin
      set_in(vt[i].rst, vt[i].req0, vt[i].req1, vt[i].op0, vt[i].a0, vt[i].b0,
             vt[i].op1, vt[i].a1, vt[i].b1);
      tick();
      cmp_vec($sformatf("vec%0d", i), obs[0], vt[i].exp);
    end

    // Reset in the middle of a 3-cycle EXEC for requester 1.
    set_in(1, 0,0, 0,0,0, 0,0,0);
    tick();
    cmp_vec("rstexec.reset", obs[1], 9'b0_0000_0000);
    set_in(0, 0,1, 0,0,0, 0,1,1);
    tick();
    cmp_vec("rstexec.gnt1", obs[1], {5'b01001, 4'd0});
    tick();
    cmp_vec("rstexec.exec", obs[1], {5'b00001, 4'd0});
    set_in(1, 0,1, 0,0,0, 0,1,1);
    tick();
    cmp_vec("rstexec.abort", obs[1], 9'b0_0000_0000);
    set_in(0, 1,1, 0,3,4, 0,1,1);
    tick();
    cmp_vec("rstexec.gnt0", obs[1], {5'b10001, 4'd0});
    tick();
    cmp_vec("rstexec.exec1", obs[1], {5'b00001, 4'd0});
    tick();
    cmp_vec("rstexec.exec2", obs[1], {5'b00001, 4'd0});
    tick();
    cmp_vec("rstexec.done0", obs[1], {5'b00101, 4'd7});
    set_in(0, 0,0, 0,0,0, 0,0,0);
    tick();
    cmp_vec("rstexec.idle", obs[1], {5'b00000, 4'd7});
    tick();

    // Random traffic, including reset pulses and operand churn while busy.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 63) == 0);
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      op0  = 2'($urandom_range(0, 3));
      op1  = 2'($urandom_range(0, 3));
      a0   = 3'($urandom_range(0, 7));
      b0   = 3'($urandom_range(0, 7));
      a1   = 3'($urandom_range(0, 7));
      b1   = 3'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
